// File: rtl/edge_event_arbiter.sv
// Multi-channel edge detector that latches edges as pending events and serialises them
// round-robin onto one valid/ready port. Define EDGE_ARB_TIMESTAMP_EN to add per-event timestamps (evt_ts).
module edge_event_arbiter #(
    parameter int N_CH = 4,
    parameter int CH_W = 2,
    parameter int TS_W = 16
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [N_CH-1:0] data_in,
    input  logic [N_CH-1:0] ch_en,
    input  logic [1:0]      edge_sel,
    input  logic [N_CH-1:0] ovf_clr,
    output logic            evt_valid,
    input  logic            evt_ready,
    output logic [CH_W-1:0] evt_ch,
    output logic            evt_level,
    output logic [N_CH-1:0] pending,
    output logic [N_CH-1:0] ovf
`ifdef EDGE_ARB_TIMESTAMP_EN
    ,
    output logic [TS_W-1:0] evt_ts
`endif
);

    // state   | meaning
    // IDLE    | no event presented; arbitrate over enabled pending channels
    // PRESENT | evt_valid high, evt_ch/evt_level frozen until evt_ready
    typedef enum logic {IDLE, PRESENT} state_t;

    if (CH_W != $clog2(N_CH)) begin : g_bad_ch_w
        $error("edge_event_arbiter: CH_W must equal clog2(N_CH)");
    end
    if (TS_W < 1) begin : g_bad_ts_w
        $error("edge_event_arbiter: TS_W must be at least 1");
    end

    state_t          state;
    logic [N_CH-1:0] q1, q2;
    logic [N_CH-1:0] rise, fall, raw_det, det;
    logic [N_CH-1:0] lvl;
    logic [N_CH-1:0] acc_vec, presented;
    logic [N_CH-1:0] lvl_load, ovf_set;
    logic [N_CH-1:0] req;
    logic [CH_W-1:0] rr_ptr;
    logic [CH_W-1:0] scan_ch;
    logic [CH_W-1:0] grant_ch;
    logic            grant_found;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            q1 <= '0;
            q2 <= '0;
        end else begin
            q1 <= data_in;
            q2 <= q1;
        end
    end

    always_comb begin
        rise    = q1 & ~q2;
        fall    = ~q1 & q2;
        raw_det = '0;
        case (edge_sel)
            2'b00:   raw_det = rise | fall;
            2'b01:   raw_det = rise;
            2'b10:   raw_det = fall;
            default: raw_det = '0;
        endcase
        det = raw_det & ch_en;
    end

    always_comb begin
        acc_vec   = '0;
        presented = '0;
        for (int i = 0; i < N_CH; i++) begin
            acc_vec[i]   = evt_valid & evt_ready & (evt_ch == CH_W'(i));
            presented[i] = (state == PRESENT) & (evt_ch == CH_W'(i));
        end
        // a fresh edge in the accept cycle restarts the event rather than overflowing
        lvl_load = det & (~pending | acc_vec);
        ovf_set  = det & pending & ~acc_vec;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pending <= '0;
            ovf     <= '0;
            lvl     <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (lvl_load[i]) begin
                    pending[i] <= 1'b1;
                    lvl[i]     <= q1[i];
                end else if (acc_vec[i] || (!ch_en[i] && !presented[i])) begin
                    pending[i] <= 1'b0;
                end
                if (ovf_set[i]) begin
                    ovf[i] <= 1'b1;
                end else if (ovf_clr[i]) begin
                    ovf[i] <= 1'b0;
                end
            end
        end
    end

    // Scan downward so the last hit written is the nearest one at or after rr_ptr.
    always_comb begin
        req         = pending & ch_en;
        grant_found = |req;
        grant_ch    = '0;
        scan_ch     = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            scan_ch = CH_W'((int'(rr_ptr) + k) % N_CH);
            if (req[scan_ch]) begin
                grant_ch = scan_ch;
            end
        end
    end

`ifdef EDGE_ARB_TIMESTAMP_EN
    logic [TS_W-1:0] ts_cnt;
    logic [TS_W-1:0] ts_reg [N_CH];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ts_cnt <= '0;
            for (int i = 0; i < N_CH; i++) begin
                ts_reg[i] <= '0;
            end
        end else begin
            ts_cnt <= ts_cnt + TS_W'(1);
            for (int i = 0; i < N_CH; i++) begin
                if (lvl_load[i]) begin
                    ts_reg[i] <= ts_cnt;
                end
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            evt_valid <= 1'b0;
            evt_ch    <= '0;
            evt_level <= 1'b0;
            rr_ptr    <= '0;
`ifdef EDGE_ARB_TIMESTAMP_EN
            evt_ts    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        evt_valid <= 1'b1;
                        evt_ch    <= grant_ch;
                        evt_level <= lvl[grant_ch];
`ifdef EDGE_ARB_TIMESTAMP_EN
                        evt_ts    <= ts_reg[grant_ch];
`endif
                        state     <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (evt_ready) begin
                        evt_valid <= 1'b0;
                        rr_ptr    <= (evt_ch == CH_W'(N_CH - 1)) ? '0 : evt_ch + CH_W'(1);
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    evt_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Scoreboard bench for edge_event_arbiter: directed edges push expected {ch, level}
// events; a negedge monitor pops and compares on every accepted handshake.
module tb_edge_event_arbiter;

    localparam int N_CH = 4;
    localparam int CH_W = 2;
    localparam int TS_W = 16;

    logic            clk;
    logic            resetn;
    logic [N_CH-1:0] data_in;
    logic [N_CH-1:0] ch_en;
    logic [1:0]      edge_sel;
    logic [N_CH-1:0] ovf_clr;
    logic            evt_valid;
    logic            evt_ready;
    logic [CH_W-1:0] evt_ch;
    logic            evt_level;
    logic [N_CH-1:0] pending;
    logic [N_CH-1:0] ovf;
`ifdef EDGE_ARB_TIMESTAMP_EN
    logic [TS_W-1:0] evt_ts;
`endif

    int total = 0;
    int bad   = 0;
    logic [CH_W:0] exp_q [$];

    edge_event_arbiter #(.N_CH(N_CH), .CH_W(CH_W), .TS_W(TS_W)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .data_in   (data_in),
        .ch_en     (ch_en),
        .edge_sel  (edge_sel),
        .ovf_clr   (ovf_clr),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_ch    (evt_ch),
        .evt_level (evt_level),
        .pending   (pending),
`ifdef EDGE_ARB_TIMESTAMP_EN
        .evt_ts    (evt_ts),
`endif
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_evt(input int ch, input logic lvl_v);
        exp_q.push_back({CH_W'(ch), lvl_v});
    endtask

    always @(negedge clk) begin
        if (resetn && evt_valid && evt_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_event: got ch=%0d lvl=%0b expected none", evt_ch, evt_level);
            end else begin
                logic [CH_W:0] e;
                e = exp_q.pop_front();
                if ({evt_ch, evt_level} !== e) begin
                    bad++;
                    $display("FAIL event: got ch=%0d lvl=%0b expected ch=%0d lvl=%0b",
                             evt_ch, evt_level, e[CH_W:1], e[0]);
                end
            end
        end
    end

    initial begin
        resetn    = 1'b0;
        data_in   = '0;
        ch_en     = 4'hF;
        edge_sel  = 2'b01;
        ovf_clr   = '0;
        evt_ready = 1'b1;
        cyc(3);
        chk("reset_valid", 32'(evt_valid), 0);
        chk("reset_pending", 32'(pending), 0);
        chk("reset_ovf", 32'(ovf), 0);
        chk("reset_ch", 32'(evt_ch), 0);
        resetn = 1'b1;
        cyc(2);

        // single rise on ch2
        expect_evt(2, 1'b1);
        data_in[2] = 1'b1;
        cyc(2);
        chk("rise_pending_t1", 32'(pending), 32'h4);
        chk("rise_valid_t1", 32'(evt_valid), 0);
        cyc(1);
        chk("rise_valid_t2", 32'(evt_valid), 1);
        chk("rise_ch_t2", 32'(evt_ch), 2);
        cyc(1);
        chk("rise_valid_t3", 32'(evt_valid), 0);
        chk("rise_pending_t3", 32'(pending), 0);
        data_in[2] = 1'b0;
        cyc(3);

        // falling-only filter, then no-edge mode
        edge_sel   = 2'b10;
        data_in[0] = 1'b1;
        cyc(5);
        chk("fall_ignore_rise", 32'(pending), 0);
        expect_evt(0, 1'b0);
        data_in[0] = 1'b0;
        cyc(6);
        chk("fall_done_valid", 32'(evt_valid), 0);
        edge_sel   = 2'b11;
        data_in[0] = 1'b1;
        cyc(5);
        data_in[0] = 1'b0;
        cyc(5);
        chk("none_pending", 32'(pending), 0);
        chk("none_valid", 32'(evt_valid), 0);
        edge_sel = 2'b01;

        // ch3 first so rr_ptr wraps to 0
        expect_evt(3, 1'b1);
        data_in[3] = 1'b1;
        cyc(5);
        data_in[3] = 1'b0;
        cyc(3);

        // round-robin over {0,1,3}
        expect_evt(0, 1'b1);
        expect_evt(1, 1'b1);
        expect_evt(3, 1'b1);
        data_in = 4'b1011;
        cyc(3);
        chk("rr_first_ch", 32'(evt_ch), 0);
        cyc(1);
        chk("rr_bubble", 32'(evt_valid), 0);
        cyc(1);
        chk("rr_second_ch", 32'(evt_ch), 1);
        cyc(2);
        chk("rr_third_ch", 32'(evt_ch), 3);
        chk("rr_third_valid", 32'(evt_valid), 1);
        cyc(1);
        data_in = '0;
        cyc(3);
        expect_evt(0, 1'b1);
        expect_evt(3, 1'b1);
        data_in = 4'b1001;
        cyc(3);
        chk("rr_wrap_first", 32'(evt_ch), 0);
        cyc(2);
        chk("rr_wrap_second", 32'(evt_ch), 3);
        cyc(2);

        // backpressure and overflow on ch1
        evt_ready  = 1'b0;
        expect_evt(1, 1'b1);
        data_in[1] = 1'b1;
        cyc(4);
        chk("bp_valid", 32'(evt_valid), 1);
        chk("bp_ch", 32'(evt_ch), 1);
        data_in[1] = 1'b0;
        cyc(3);
        data_in[1] = 1'b1;
        cyc(3);
        chk("bp_ovf", 32'(ovf), 32'h2);
        chk("bp_ch_held", 32'(evt_ch), 1);
        chk("bp_level_held", 32'(evt_level), 1);
        evt_ready = 1'b1;
        cyc(1);
        chk("bp_accept_valid", 32'(evt_valid), 0);
        chk("bp_accept_pending", 32'(pending), 0);
        cyc(3);
        chk("bp_ovf_sticky", 32'(ovf), 32'h2);
        ovf_clr = 4'b0010;
        cyc(1);
        ovf_clr = '0;
        chk("bp_ovf_clr", 32'(ovf), 0);

        // edge on ch2 in the same cycle ch2 is accepted
        evt_ready  = 1'b0;
        expect_evt(2, 1'b1);
        expect_evt(2, 1'b1);
        data_in[2] = 1'b1;
        cyc(4);
        chk("col_ch", 32'(evt_ch), 2);
        data_in[2] = 1'b0;
        cyc(2);
        data_in[2] = 1'b1;
        cyc(1);
        evt_ready = 1'b1;
        cyc(1);
        chk("col_pending", 32'(pending), 32'h4);
        chk("col_ovf", 32'(ovf), 0);
        chk("col_bubble", 32'(evt_valid), 0);
        cyc(1);
        chk("col_represent_valid", 32'(evt_valid), 1);
        chk("col_represent_ch", 32'(evt_ch), 2);
        cyc(1);
        chk("col_done_pending", 32'(pending), 0);

        // disabling channels: pending ch1 drops, presented ch0 holds
        data_in[1:0] = 2'b00;
        cyc(3);
        evt_ready    = 1'b0;
        data_in[1:0] = 2'b11;
        cyc(3);
        chk("dis_ch", 32'(evt_ch), 0);
        chk("dis_pending_before", 32'(pending), 32'h3);
        ch_en = 4'b1100;
        cyc(1);
        chk("dis_pending_after", 32'(pending), 32'h1);
        chk("dis_presented_held", 32'(evt_valid), 1);
        expect_evt(0, 1'b1);
        evt_ready = 1'b1;
        cyc(1);
        chk("dis_accept_pending", 32'(pending), 0);
        ch_en = 4'hF;
        cyc(3);
        chk("dis_no_ch1", 32'(evt_valid), 0);

        // reset while presenting
        data_in[0] = 1'b0;
        cyc(3);
        evt_ready  = 1'b0;
        data_in[0] = 1'b1;
        cyc(4);
        data_in[0] = 1'b0;
        cyc(2);
        data_in[0] = 1'b1;
        cyc(3);
        chk("rst_pre_valid", 32'(evt_valid), 1);
        chk("rst_pre_ovf", 32'(ovf), 32'h1);
        resetn = 1'b0;
        #2;
        chk("rst_async_valid", 32'(evt_valid), 0);
        chk("rst_async_pending", 32'(pending), 0);
        chk("rst_async_ovf", 32'(ovf), 0);
        data_in = '0;
        cyc(2);
        resetn    = 1'b1;
        evt_ready = 1'b1;
        cyc(6);
        chk("rst_post_valid", 32'(evt_valid), 0);
        chk("rst_post_pending", 32'(pending), 0);

        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
